pc_fetch_unit: RTL and testbench

- Instruction-fetch and decode stage that sits directly upstream of the datapath in the Harvard 5-instruction CPU.
- Holds the program counter and drives the instruction-memory address.
- Splits the fetched word into the rs/rt/rd/func_code/ALUOp/immediate fields that the datapath consumes.
- Implements J and JR with a one-instruction MIPS branch delay slot, and halts the CPU when control jumps to HALT_ADDR.

---
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and fetch/decode stage for the five-instruction CPU.
// Implements J and JR with one delay slot; a jump to HALT_ADDR stops fetch.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr_readdata,
  input  logic [31:0] jr_target,
  output logic [31:0] instr_address,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  func_code,
  output logic [5:0]  ALUOp,
  output logic [15:0] alu_immediate,
  output logic        instr_valid,
  output logic        active
);

  typedef enum logic [1:0] {
    RUN,
    DELAY,
    HALTED
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target_reg;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_j;
  logic        is_jr;
  logic        run_q;

  assign opcode   = instr_readdata[31:26];
  assign funct    = instr_readdata[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign is_j     = (opcode == 6'h02);
  assign is_jr    = (opcode == 6'h00) && (funct == 6'h08);

  // J keeps the upper nibble of the delay-slot address.
  always_comb begin
    jump_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
    if (is_jr) jump_target = jr_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      state      <= RUN;
      target_reg <= '0;
      run_q      <= 1'b1;
    end else if (clk_enable) begin
      unique case (state)
        RUN: begin
          pc <= pc_plus4;
          if (is_j || is_jr) begin
            target_reg <= jump_target;
            state      <= DELAY;
          end
        end
        // A jump sitting in the slot is ignored; the pending target wins.
        DELAY: begin
          pc <= target_reg;
          if (target_reg == HALT_ADDR) begin
            state <= HALTED;
            run_q <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        HALTED: begin
          pc    <= HALT_ADDR;
          run_q <= 1'b0;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign instr_address = pc;
  assign active        = run_q;
  assign instr_valid   = run_q;

  // Once halted the datapath sees sll $0,$0,0.
  always_comb begin
    rs            = '0;
    rt            = '0;
    rd            = '0;
    func_code     = '0;
    ALUOp         = '0;
    alu_immediate = '0;
    if (run_q) begin
      rs            = instr_readdata[25:21];
      rt            = instr_readdata[20:16];
      rd            = instr_readdata[15:11];
      func_code     = instr_readdata[5:0];
      ALUOp         = instr_readdata[31:26];
      alu_immediate = instr_readdata[15:0];
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit
// against a behavioural fetch model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic [31:0] word = 32'h0;
  logic [31:0] jtgt = 32'h0;
  logic [31:0] instr_address;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  func_code, ALUOp;
  logic [15:0] alu_immediate;
  logic        instr_valid, active;

  int total = 0;
  int bad = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .instr_readdata (word),
    .jr_target      (jtgt),
    .instr_address  (instr_address),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .func_code      (func_code),
    .ALUOp          (ALUOp),
    .alu_immediate  (alu_immediate),
    .instr_valid    (instr_valid),
    .active         (active)
  );

  always #10 clk = ~clk;

  // Model: current pc, whether the current word is a delay slot,
  // the target it will go to, and whether the CPU has halted.
  logic [31:0] m_pc = RV;
  logic [31:0] m_tgt = 32'h0;
  bit          m_slot = 1'b0;
  bit          m_halt = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc   <= RV;
      m_slot <= 1'b0;
      m_halt <= 1'b0;
    end else if (clk_enable && !m_halt) begin
      if (m_slot) begin
        m_slot <= 1'b0;
        m_pc   <= m_tgt;
        m_halt <= (m_tgt == 32'h0);
      end else begin
        m_pc <= m_pc + 32'd4;
        if ((word >> 26) == 32'd2) begin
          m_slot <= 1'b1;
          m_tgt  <= ((m_pc + 32'd4) & 32'hF000_0000)
                  | ((word & 32'h03FF_FFFF) << 2);
        end else if ((word >> 26) == 32'd0 && (word & 32'h3F) == 32'h8) begin
          m_slot <= 1'b1;
          m_tgt  <= jtgt;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input int sh, input int bits);
    if (m_halt) return 32'h0;
    return (word >> sh) & ((32'h1 << bits) - 32'h1);
  endfunction

  always @(negedge clk) begin
    chk("addr", instr_address, m_pc);
    chk("active", {31'h0, active}, {31'h0, !m_halt});
    chk("valid", {31'h0, instr_valid}, {31'h0, !m_halt});
    chk("rs", {27'h0, rs}, fld(21, 5));
    chk("rt", {27'h0, rt}, fld(16, 5));
    chk("rd", {27'h0, rd}, fld(11, 5));
    chk("func", {26'h0, func_code}, fld(0, 6));
    chk("aluop", {26'h0, ALUOp}, fld(26, 6));
    chk("imm", {16'h0, alu_immediate}, fld(0, 16));
  end

  task automatic present(input logic [31:0] w, input logic [31:0] jt,
                         input logic en);
    word = w;
    jtgt = jt;
    clk_enable = en;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_addr", instr_address, RV);
    chk("rst_active", {31'h0, active}, 32'h1);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    if (k == 0) w[31:26] = 6'h02;
    if (k == 1) begin
      w[31:26] = 6'h00;
      w[5:0]   = 6'h08;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] jt;
    #1;
    present(32'h0, 32'h0, 1'b1);
    do_reset();

    // Sequential fetch and addiu field split.
    present(32'h24020005, 32'h0, 1'b1);
    chk("t_addr0", instr_address, 32'hBFC00000);
    chk("t_rs", {27'h0, rs}, 32'h0);
    chk("t_rt", {27'h0, rt}, 32'h2);
    chk("t_aluop", {26'h0, ALUOp}, 32'h09);
    chk("t_imm", {16'h0, alu_immediate}, 32'h0005);
    chk("t_valid", {31'h0, instr_valid}, 32'h1);
    tick();
    chk("t_addr1", instr_address, 32'hBFC00004);
    present(32'h00221820, 32'h0, 1'b1);
    tick();
    chk("t_addr2", instr_address, 32'hBFC00008);
    tick();
    chk("t_addr3", instr_address, 32'hBFC0000C);
    chk("t_act3", {31'h0, active}, 32'h1);
    tick();

    // J 0x40 at BFC00010 with a frozen delay slot.
    present(32'h08000040, 32'h0, 1'b1);
    chk("j_addr", instr_address, 32'hBFC00010);
    tick();
    chk("j_slot", instr_address, 32'hBFC00014);
    for (int i = 0; i < 4; i++) begin
      present(32'h24020005, 32'h0, 1'b0);
      tick();
      chk("j_frozen", instr_address, 32'hBFC00014);
    end
    present(32'h24020005, 32'h0, 1'b1);
    tick();
    chk("j_target", instr_address, 32'hB0000100);
    chk("j_active", {31'h0, active}, 32'h1);

    // JR to 0 halts after its delay slot.
    do_reset();
    present(32'h03E00008, 32'h0, 1'b1);
    tick();
    chk("jr_slot", instr_address, 32'hBFC00004);
    present(32'h24020005, 32'h12345678, 1'b1);
    chk("jr_slot_valid", {31'h0, instr_valid}, 32'h1);
    chk("jr_slot_rt", {27'h0, rt}, 32'h2);
    tick();
    for (int i = 0; i < 11; i++) begin
      chk("halt_addr", instr_address, 32'h0);
      chk("halt_active", {31'h0, active}, 32'h0);
      chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      chk("halt_aluop", {26'h0, ALUOp}, 32'h0);
      chk("halt_imm", {16'h0, alu_immediate}, 32'h0);
      present($urandom, $urandom, 1'b1);
      tick();
    end

    // Async reset in a halting delay slot discards the jump.
    do_reset();
    present(32'h03E00008, 32'h0, 1'b1);
    tick();
    present(32'h24020005, 32'h0, 1'b1);
    reset = 1'b1;
    #1;
    chk("ar_addr", instr_address, 32'hBFC00000);
    chk("ar_active", {31'h0, active}, 32'h1);
    #1;
    reset = 1'b0;
    tick();
    chk("ar_next", instr_address, 32'hBFC00004);
    chk("ar_run", {31'h0, active}, 32'h1);
    tick();
    chk("ar_next2", instr_address, 32'hBFC00008);

    // Sequential wrap does not halt.
    present(32'h03E00008, 32'hFFFFFFF8, 1'b1);
    tick();
    present(32'h0, 32'h0, 1'b1);
    tick();
    chk("wrap_a", instr_address, 32'hFFFFFFF8);
    tick();
    tick();
    chk("wrap_b", instr_address, 32'h00000000);
    tick();
    chk("wrap_c", instr_address, 32'h00000004);
    chk("wrap_act", {31'h0, active}, 32'h1);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      jt = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      present(rand_word(), jt, $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
